// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
// Shares the single try_push/push_success port of a FIFO among N_REQ
// producers. Arbitration is round-robin with a bounded burst lock: once a
// requester has a push accepted it keeps the port for up to MAX_BURST
// accepted pushes, then priority rotates to the next index.
// The grant is combinational, so request and success happen in the same cycle.
//
// Ports:
//   clk                  clock
//   rst                  synchronous, active-high reset; forces all outputs to 0
//   i_req_try_push       per-requester push request
//   i_req_data           per-requester data, slice i = [i*W +: W]
//   o_req_push_success   one-hot: push of requester i accepted this cycle
//   o_fifo_try_push      push request to the FIFO
//   o_fifo_push_data     data of the granted requester (0 when idle)
//   i_fifo_push_success  FIFO accepted the push (combinational response)
//   o_grant_valid        some requester is granted this cycle
//   o_grant_id           granted index, 0 when nothing is granted
//   o_push_count         accepted pushes since reset, wraps at 2^32
module fifo_push_arbiter #(
  parameter int N_REQ     = 4,
  parameter int W         = 32,
  parameter int MAX_BURST = 3,
  localparam int IDW      = (N_REQ > 2) ? $clog2(N_REQ) : 1,
  localparam int BCW      = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   i_req_try_push,
  input  logic [N_REQ*W-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_push_success,
  output logic               o_fifo_try_push,
  output logic [W-1:0]       o_fifo_push_data,
  input  logic               i_fifo_push_success,
  output logic               o_grant_valid,
  output logic [IDW-1:0]     o_grant_id,
  output logic [31:0]        o_push_count
);

  logic           r_locked;
  logic [IDW-1:0] r_owner;
  logic [BCW-1:0] r_burstCnt;
  logic [IDW-1:0] r_rrPtr;
  logic [31:0]    r_pushCount;

  logic           w_ownerActive;
  logic           w_grantValid;
  logic [IDW-1:0] w_grantId;
  logic           w_accept;
  logic [BCW-1:0] w_baseCnt;

  // Circular successor of an index, wrapping N_REQ-1 back to 0.
  function automatic logic [IDW-1:0] nextIdx(input logic [IDW-1:0] x);
    return (int'(x) == N_REQ - 1) ? '0 : x + 1'b1;
  endfunction

  // Grant selection. A locked owner that still requests keeps the port;
  // otherwise the first requester found scanning circularly from r_rrPtr
  // wins. Reset suppresses the grant so nothing leaks out while rst is high.
  always_comb begin
    int scanIdx;
    scanIdx       = 0;
    w_grantValid  = 1'b0;
    w_grantId     = '0;
    w_ownerActive = r_locked & i_req_try_push[r_owner];
    if (w_ownerActive) begin
      w_grantValid = 1'b1;
      w_grantId    = r_owner;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        scanIdx = int'(r_rrPtr) + k;
        if (scanIdx >= N_REQ) scanIdx = scanIdx - N_REQ;
        if (!w_grantValid && i_req_try_push[scanIdx]) begin
          w_grantValid = 1'b1;
          w_grantId    = IDW'(scanIdx);
        end
      end
    end
    if (rst) begin
      w_grantValid = 1'b0;
      w_grantId    = '0;
    end
  end

  // Burst count the next accept builds on: if the lock is being dropped
  // this cycle, a newly granted requester starts a fresh burst from zero.
  assign w_baseCnt = w_ownerActive ? r_burstCnt : '0;
  assign w_accept  = w_grantValid & i_fifo_push_success;

  // Output steering. Success from the FIFO only counts while we are actually
  // asking, so a stray i_fifo_push_success with no try_push is ignored.
  always_comb begin
    o_grant_valid      = w_grantValid;
    o_grant_id         = w_grantId;
    o_fifo_try_push    = w_grantValid;
    o_fifo_push_data   = '0;
    o_req_push_success = '0;
    o_push_count       = rst ? 32'd0 : r_pushCount;
    if (w_grantValid) o_fifo_push_data = i_req_data[w_grantId*W +: W];
    if (w_accept) o_req_push_success = N_REQ'(1) << w_grantId;
  end

  // Lock/burst bookkeeping. An accept either extends the owner's burst or,
  // on the last beat, releases the lock and moves priority past the grantee.
  // A stalled (not accepted) grant changes nothing, so the lock survives
  // backpressure. An owner that stops requesting loses the lock and priority
  // moves past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked    <= 1'b0;
      r_owner     <= '0;
      r_burstCnt  <= '0;
      r_rrPtr     <= '0;
      r_pushCount <= 32'd0;
    end else begin
      if (w_accept) begin
        r_pushCount <= r_pushCount + 32'd1;
        if (int'(w_baseCnt) + 1 == MAX_BURST) begin
          r_locked   <= 1'b0;
          r_burstCnt <= '0;
          r_rrPtr    <= nextIdx(w_grantId);
        end else begin
          r_locked   <= 1'b1;
          r_owner    <= w_grantId;
          r_burstCnt <= w_baseCnt + 1'b1;
          if (r_locked && !w_ownerActive) r_rrPtr <= nextIdx(r_owner);
        end
      end else if (r_locked && !w_ownerActive) begin
        r_locked   <= 1'b0;
        r_burstCnt <= '0;
        r_rrPtr    <= nextIdx(r_owner);
      end
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter
// Table-driven bench for fifo_push_arbiter (N_REQ=4, W=32, MAX_BURST=3).
// Each vector row holds the inputs for one cycle plus the expected grant.
// Expected push data is queued when a row expecting a grant is driven and
// popped whenever the DUT raises o_fifo_try_push. The accepted-push count
// is tracked by a running counter in the bench.
module tb_fifo_push_arbiter;

  localparam int N_REQ     = 4;
  localparam int W         = 32;
  localparam int MAX_BURST = 3;
  localparam int IDW       = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   reqTryPush;
  logic [N_REQ*W-1:0] reqData;
  logic [N_REQ-1:0]   reqPushSuccess;
  logic               fifoTryPush;
  logic [W-1:0]       fifoPushData;
  logic               fifoPushSuccess;
  logic               grantValid;
  logic [IDW-1:0]     grantId;
  logic [31:0]        pushCount;

  typedef struct {
    logic             rst;
    logic [N_REQ-1:0] req;
    logic             succ;
    logic             expValid;
    logic [IDW-1:0]   expId;
  } vec_t;

  vec_t        vecs[$];
  logic [W-1:0] expData[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          expCount   = 0;

  fifo_push_arbiter #(.N_REQ(N_REQ), .W(W), .MAX_BURST(MAX_BURST)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_req_try_push      (reqTryPush),
    .i_req_data          (reqData),
    .o_req_push_success  (reqPushSuccess),
    .o_fifo_try_push     (fifoTryPush),
    .o_fifo_push_data    (fifoPushData),
    .i_fifo_push_success (fifoPushSuccess),
    .o_grant_valid       (grantValid),
    .o_grant_id          (grantId),
    .o_push_count        (pushCount)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Append n identical rows to the vector table.
  task automatic addVec(input int n, input logic r, input logic [N_REQ-1:0] q,
                        input logic s, input logic v, input logic [IDW-1:0] id);
    vec_t row;
    row = '{r, q, s, v, id};
    repeat (n) vecs.push_back(row);
  endtask

  // Distinct data word per vector row and requester.
  function automatic logic [W-1:0] wordFor(input int vi, input int ri);
    return 32'hDA7A_0000 | (W'(vi & 255) << 8) | W'(ri);
  endfunction

  task automatic cmp(input string name, input int vi, input logic [31:0] act,
                     input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s (row %0d): got 0x%0h, required 0x%0h", name, vi, act, req);
    end
  endtask

  // Drive one row's inputs and queue the data the FIFO should see.
  task automatic applyStimulus(input int vi);
    rst             = vecs[vi].rst;
    reqTryPush      = vecs[vi].req;
    fifoPushSuccess = vecs[vi].succ;
    for (int i = 0; i < N_REQ; i++) reqData[i*W +: W] = wordFor(vi, i);
    if (vecs[vi].expValid) expData.push_back(wordFor(vi, int'(vecs[vi].expId)));
  endtask

  // Compare all DUT outputs for the current row.
  task automatic checkOutput(input int vi);
    logic [N_REQ-1:0] expPs;
    logic [W-1:0]     want;
    expPs = '0;
    if (vecs[vi].expValid && vecs[vi].succ) expPs[vecs[vi].expId] = 1'b1;
    cmp("grant_valid", vi, 32'(grantValid), 32'(vecs[vi].expValid));
    cmp("grant_id", vi, 32'(grantId), 32'(vecs[vi].expId));
    cmp("fifo_try_push", vi, 32'(fifoTryPush), 32'(vecs[vi].expValid));
    cmp("req_push_success", vi, 32'(reqPushSuccess), 32'(expPs));
    cmp("push_count", vi, pushCount, vecs[vi].rst ? 32'd0 : 32'(expCount));
    if (fifoTryPush) begin
      if (expData.size() == 0) begin
        cmp("fifo_push_data_unexpected", vi, 32'(fifoPushData), 32'd0);
        if (fifoPushData == 32'd0) begin
          mismatched++;
          $display("[TB] FAIL fifo_push_data_unexpected (row %0d): got try_push, required none", vi);
        end
      end else begin
        want = expData.pop_front();
        cmp("fifo_push_data", vi, fifoPushData, want);
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    reqTryPush      = '0;
    reqData         = '0;
    fifoPushSuccess = 1'b0;

    // Reset held with everything requesting and the FIFO accepting.
    addVec(5, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0);
    // All requesting: bursts of 3, rotation wraps 3 -> 0.
    addVec(3, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd0);
    addVec(3, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd1);
    addVec(3, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd2);
    addVec(3, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd3);
    addVec(1, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd0);
    addVec(1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    // Sole requester 2: no bubble between bursts.
    addVec(1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    addVec(10, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2);
    addVec(1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    // Backpressure holds requester 1's grant, then it finishes its burst.
    addVec(1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    addVec(3, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd0);
    addVec(1, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd1);
    addVec(5, 1'b0, 4'b1111, 1'b0, 1'b1, 2'd1);
    addVec(2, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd1);
    addVec(1, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd2);
    // Owner 0 drops after one accept; 1 and 3 are served before 0 again.
    addVec(1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    addVec(1, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd0);
    addVec(1, 1'b0, 4'b1010, 1'b0, 1'b1, 2'd1);
    addVec(3, 1'b0, 4'b1011, 1'b1, 1'b1, 2'd1);
    addVec(3, 1'b0, 4'b1011, 1'b1, 1'b1, 2'd3);
    addVec(1, 1'b0, 4'b1011, 1'b1, 1'b1, 2'd0);
    // Reset in the middle of requester 2's burst, then a fresh start at 0.
    addVec(1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    addVec(3, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd0);
    addVec(3, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd1);
    addVec(2, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd2);
    addVec(1, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0);
    addVec(3, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd0);
    addVec(1, 1'b0, 4'b1111, 1'b1, 1'b1, 2'd1);
    // Stray FIFO success with no request is ignored.
    addVec(2, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);

    @(negedge clk);
    for (int vi = 0; vi < vecs.size(); vi++) begin
      applyStimulus(vi);
      #1;
      checkOutput(vi);
      @(posedge clk);
      if (vecs[vi].rst) expCount = 0;
      else if (vecs[vi].expValid && vecs[vi].succ) expCount++;
      @(negedge clk);
    end

    cmp("scoreboard_left", vecs.size(), 32'(expData.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
